// File: rtl/stream_mux_pkg.sv
// Shared constants for the N-channel stream multiplexer: state encoding, select modes and
// the channel-index width helper.
package stream_mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the lowest requesting index at or after ptr,
// wrapping modulo N.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  logic [SELW-1:0] cand;
  logic            found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = SELW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_valid = |req;

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with packet locking; the channel is chosen per packet by
// sel (MODE_SEL) or by round-robin arbitration (MODE_RR).
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = MODE_SEL,
  parameter int unsigned SELW  = idx_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic            state;
  logic [SELW-1:0] lock_chan;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_next;

  logic [SELW-1:0] arb_idx;
  logic            arb_valid;
  logic [SELW-1:0] grant;
  logic            grant_valid;

  logic             space;
  logic             load;
  logic [WIDTH-1:0] g_data;
  logic             g_valid;
  logic             g_last;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(
        .N    (N),
        .SELW (SELW)
      ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
      );
    end else begin : g_sel
      // No arbiter in explicit-select mode; arb_valid=0 keeps this path unselected.
      assign arb_idx   = rr_ptr;
      assign arb_valid = 1'b0;
    end
  endgenerate

  // A locked packet owns the mux; otherwise the mode decides the candidate channel.
  always_comb begin
    if (state == LOCKED) begin
      grant       = lock_chan;
      grant_valid = 1'b1;
    end else if (MODE == MODE_RR) begin
      grant       = arb_idx;
      grant_valid = arb_valid;
    end else begin
      grant       = sel;
      grant_valid = (32'(sel) < N);
    end
  end

  assign space = !out_valid || out_ready;

  always_comb begin
    g_data   = '0;
    g_valid  = 1'b0;
    g_last   = 1'b0;
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        g_data      = in_data[i*WIDTH +: WIDTH];
        g_valid     = in_valid[i];
        g_last      = in_last[i];
        in_ready[i] = space && grant_valid && !rst;
      end
    end
  end

  assign load    = space && grant_valid && g_valid;
  assign rr_next = (32'(grant) == N - 1) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_chan <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      if (load) begin
        out_data  <= g_data;
        out_last  <= g_last;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (state == IDLE && !g_last) begin
          state     <= LOCKED;
          lock_chan <= grant;
        end else if (state == LOCKED && g_last) begin
          state <= IDLE;
        end
        if (g_last && MODE == MODE_RR) begin
          rr_ptr <= rr_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
